// File: rtl/button_press_classifier_if.sv
// Bundles the debounced button level and the classified event pulses.
// The master drives btn_in and observes events; the slave is the classifier.
interface button_press_classifier_if;
    logic btn_in;
    logic pressed;
    logic rise_pulse;
    logic fall_pulse;
    logic short_press;
    logic long_press;
    logic double_click;

    modport master (
        output btn_in,
        input  pressed,
        input  rise_pulse,
        input  fall_pulse,
        input  short_press,
        input  long_press,
        input  double_click
    );

    modport slave (
        input  btn_in,
        output pressed,
        output rise_pulse,
        output fall_pulse,
        output short_press,
        output long_press,
        output double_click
    );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies a clean, clk-synchronous button level into edge/short/long pulses.
// Define BTN_DOUBLE_CLICK_EN to add double-click detection (WAIT2/HELD2 states).
module button_press_classifier #(
    parameter int LONG_CYC = 20,
    parameter int DC_WIN   = 10,
    parameter int CNT_W    = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    button_press_classifier_if.slave bus
);

`ifdef BTN_DOUBLE_CLICK_EN
    typedef enum logic [2:0] {IDLE, HELD, LONG, WAIT2, HELD2} state_t;
    localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DC_WIN);
`else
    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
`endif

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    // Saturation point: the counter can never legitimately pass either limit.
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((LONG_CYC > DC_WIN) ? LONG_CYC : DC_WIN);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             btn_q_reg;
    logic             rise_reg, fall_reg;
    logic             short_reg, short_next;
    logic             long_reg, long_next;
`ifdef BTN_DOUBLE_CLICK_EN
    logic             dbl_reg, dbl_next;
`endif

    assign cnt_inc = (cnt_reg == CNT_LIMIT) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        short_next = 1'b0;
        long_next  = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
        dbl_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.btn_in) begin
                    state_next = HELD;
                    cnt_next   = CNT_W'(1);
                end
            end
            HELD: begin
                if (bus.btn_in) begin
                    if (cnt_reg == LONG_LAST) begin
                        long_next  = 1'b1;
                        state_next = LONG;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
`ifdef BTN_DOUBLE_CLICK_EN
                    // Hold back the short decision until the click window closes.
                    state_next = WAIT2;
                    cnt_next   = CNT_W'(1);
`else
                    short_next = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
`endif
                end
            end
            LONG: begin
                if (!bus.btn_in) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            WAIT2: begin
                if (bus.btn_in) begin
                    state_next = HELD2;
                    cnt_next   = CNT_W'(1);
                end else if (cnt_reg == DC_LAST) begin
                    short_next = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            HELD2: begin
                if (!bus.btn_in) begin
                    dbl_next   = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == LONG_LAST) begin
                    // Second click turned long: the pending first click is dropped.
                    long_next  = 1'b1;
                    state_next = LONG;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            btn_q_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            short_reg <= 1'b0;
            long_reg  <= 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
            dbl_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            btn_q_reg <= bus.btn_in;
            rise_reg  <= bus.btn_in & ~btn_q_reg;
            fall_reg  <= ~bus.btn_in & btn_q_reg;
            short_reg <= short_next;
            long_reg  <= long_next;
`ifdef BTN_DOUBLE_CLICK_EN
            dbl_reg   <= dbl_next;
`endif
        end
    end

    assign bus.pressed     = btn_q_reg;
    assign bus.rise_pulse  = rise_reg;
    assign bus.fall_pulse  = fall_reg;
    assign bus.short_press = short_reg;
    assign bus.long_press  = long_reg;
`ifdef BTN_DOUBLE_CLICK_EN
    assign bus.double_click = dbl_reg;
`else
    assign bus.double_click = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier: table-driven presses plus
// hand-written double-click and reset sequences, checked cycle by cycle.
module tb_button_press_classifier;
    localparam int LONG_CYC = 20;
    localparam int DC_WIN   = 10;
`ifdef BTN_DOUBLE_CLICK_EN
    localparam bit DC_ON = 1'b1;
`else
    localparam bit DC_ON = 1'b0;
`endif
    // Low sample (1-based, counted from release) on which short_press is decided.
    localparam int SHORT_LOW = DC_ON ? DC_WIN + 1 : 1;

    typedef struct packed {
        logic pressed;
        logic rise;
        logic fall;
        logic short_p;
        logic long_p;
        logic dbl;
    } outs_t;

    typedef struct {
        int high;
        int low;
        bit exp_long;
        bit exp_short;
    } press_rec_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    outs_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    step_no  = 0;
    logic  prev_b   = 1'b0;

    always #5 clk = ~clk;

    button_press_classifier_if bus ();

    button_press_classifier #(
        .LONG_CYC(LONG_CYC),
        .DC_WIN  (DC_WIN),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    function automatic outs_t actual();
        outs_t a;
        a.pressed = bus.pressed;
        a.rise    = bus.rise_pulse;
        a.fall    = bus.fall_pulse;
        a.short_p = bus.short_press;
        a.long_p  = bus.long_press;
        a.dbl     = bus.double_click;
        return a;
    endfunction

    task automatic check_vec(input string name, input outs_t got, input outs_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got pressed=%b rise=%b fall=%b short=%b long=%b dbl=%b, want pressed=%b rise=%b fall=%b short=%b long=%b dbl=%b",
                     name, got.pressed, got.rise, got.fall, got.short_p, got.long_p, got.dbl,
                     want.pressed, want.rise, want.fall, want.short_p, want.long_p, want.dbl);
        end
    endtask

    // Drive one sample; the expected outputs are queued now and compared
    // once the DUT has registered that sample.
    task automatic step(input logic b, input bit es, input bit el, input bit ed);
        outs_t e;
        e.pressed = b;
        e.rise    = b & ~prev_b;
        e.fall    = ~b & prev_b;
        e.short_p = es;
        e.long_p  = el;
        e.dbl     = ed;
        bus.btn_in = b;
        exp_q.push_back(e);
        @(negedge clk);
        step_no++;
        check_vec($sformatf("step%0d btn=%b", step_no, b), actual(), exp_q.pop_front());
        prev_b = b;
    endtask

    task automatic press(input int h, input int l, input bit el, input bit es);
        for (int i = 0; i < h; i++) step(1'b1, 1'b0, el && (i == LONG_CYC - 1), 1'b0);
        for (int i = 0; i < l; i++) step(1'b0, es && (i == SHORT_LOW - 1), 1'b0, 1'b0);
    endtask

    task automatic click_pair(input int gap);
        for (int i = 0; i < 5; i++)   step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < gap; i++) step(1'b0, !DC_ON && (i == 0), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)   step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, !DC_ON, 1'b0, DC_ON);
        for (int i = 0; i < 11; i++)  step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string name);
        outs_t z;
        z = '0;
        check_vec(name, actual(), z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        press_rec_t tbl[9];
        tbl[0] = '{5,  12, 1'b0, 1'b1};
        tbl[1] = '{1,  12, 1'b0, 1'b1};
        tbl[2] = '{19, 12, 1'b0, 1'b1};
        tbl[3] = '{20, 12, 1'b1, 1'b0};
        tbl[4] = '{21, 12, 1'b1, 1'b0};
        tbl[5] = '{2,  12, 1'b0, 1'b1};
        tbl[6] = '{40, 12, 1'b1, 1'b0};
        tbl[7] = '{18, 11, 1'b0, 1'b1};
        tbl[8] = '{3,  12, 1'b0, 1'b1};

        // Reset held with the button already pressed.
        bus.btn_in = 1'b1;
        rst_n      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        rst_n  = 1'b1;
        prev_b = 1'b0;

        for (int r = 0; r < 9; r++) press(tbl[r].high, tbl[r].low, tbl[r].exp_long, tbl[r].exp_short);

        click_pair(4);
        click_pair(10);

        // Second click held long: long only (macro on) / short then long (macro off).
        for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b0, !DC_ON && (i == 0), 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, i == LONG_CYC - 1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Long hold interrupted by an asynchronous reset, button kept pressed.
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, i == LONG_CYC - 1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset_midhold");
        repeat (2) begin
            @(negedge clk);
            check_reset("reset_midhold");
        end
        rst_n  = 1'b1;
        prev_b = 1'b0;
        press(5, 12, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
